// File: rtl/apb_initiator.sv
// APB (AMBA 2) initiator: buffers valid/ready commands in a small FIFO and issues SETUP/ACCESS
// transfers; a command accepted into an empty FIFO reaches SETUP one cycle later, reads hold RspValid until RspReady.
module apb_initiator #(
  parameter int AW    = 10,
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  input  logic          CmdValid,
  output logic          CmdReady,
  input  logic          CmdWrite,
  input  logic [AW-1:0] CmdAddr,
  input  logic [DW-1:0] CmdWData,
  output logic          PSEL,
  output logic          PENABLE,
  output logic          PWRITE,
  output logic [AW-1:0] PADDR,
  output logic [DW-1:0] PWDATA,
  input  logic [DW-1:0] PRDATA,
  output logic          RspValid,
  output logic [DW-1:0] RspData,
  input  logic          RspReady,
  output logic          Busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int EW = 1 + AW + DW;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e          state_q;
  logic [EW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            psel_q, penable_q, pwrite_q;
  logic [AW-1:0]   paddr_q;
  logic [DW-1:0]   pwdata_q;
  logic            rsp_valid_q;
  logic [DW-1:0]   rsp_data_q;

  logic            full, empty, push, pop;
  logic            head_write;
  logic [AW-1:0]   head_addr;
  logic [DW-1:0]   head_wdata;
  logic            rsp_pending, issuable;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign CmdReady = !full;
  assign push     = CmdValid && !full;

  assign {head_write, head_addr, head_wdata} = mem_q[rd_ptr_q];

  // A read in ACCESS is about to occupy the response slot, so it blocks the next read too.
  assign rsp_pending = rsp_valid_q || ((state_q == ACCESS) && !pwrite_q);
  assign issuable    = !empty && (head_write || !rsp_pending);
  assign pop         = issuable && (state_q != SETUP);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {CmdWrite, CmdAddr, CmdWData};
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      if (rsp_valid_q && RspReady) begin
        rsp_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q  <= SETUP;
            psel_q   <= 1'b1;
            pwrite_q <= head_write;
            paddr_q  <= head_addr;
            pwdata_q <= head_write ? head_wdata : '0;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          penable_q <= 1'b0;
          if (!pwrite_q) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= PRDATA;
          end
          if (pop) begin
            state_q  <= SETUP;
            pwrite_q <= head_write;
            paddr_q  <= head_addr;
            pwdata_q <= head_write ? head_wdata : '0;
          end else begin
            state_q <= IDLE;
            psel_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign PSEL     = psel_q;
  assign PENABLE  = penable_q;
  assign PWRITE   = pwrite_q;
  assign PADDR    = paddr_q;
  assign PWDATA   = pwdata_q;
  assign RspValid = rsp_valid_q;
  assign RspData  = rsp_data_q;
  assign Busy     = !empty || (state_q != IDLE);

endmodule
